// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: decode stage of a 5-stage MIPS pipeline.
// Contains the GPR file, the forwarding muxes, branch/jump resolution with next-PC,
// immediate extension and the D/E pipeline register with stall/flush.
// Optional build macro DSTAGE_RF_BYPASS_EN: a GPR read whose address matches a qualifying
// W-stage write returns wd_w in the same cycle (write-through). Without it the read returns
// the contents from before the write, and a W->D dependency needs fwd = 3.
module decode_stage_pipe #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned LINK_OFS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr_d,
    input  logic [DW-1:0] pc4_d,
    input  logic          we_w,
    input  logic [4:0]    a3_w,
    input  logic [DW-1:0] wd_w,
    input  logic [DW-1:0] alu_out_m,
    input  logic [DW-1:0] pc4_m,
    input  logic [1:0]    fwd_rs,
    input  logic [1:0]    fwd_rt,
    input  logic          stall_d,
    input  logic          flush_e,
    output logic [DW-1:0] npc,
    output logic          pc_sel,
    output logic [31:0]   instr_e,
    output logic [DW-1:0] rd1_e,
    output logic [DW-1:0] rd2_e,
    output logic [DW-1:0] ext_e,
    output logic [DW-1:0] pc4_e,
    output logic          valid_e
);

    // Opcodes and sub-codes used by the decoder
    localparam logic [5:0] OpSpecial = 6'h00;
    localparam logic [5:0] OpRegimm  = 6'h01;
    localparam logic [5:0] OpJ       = 6'h02;
    localparam logic [5:0] OpJal     = 6'h03;
    localparam logic [5:0] OpBeq     = 6'h04;
    localparam logic [5:0] OpBne     = 6'h05;
    localparam logic [5:0] OpBlez    = 6'h06;
    localparam logic [5:0] OpBgtz    = 6'h07;
    localparam logic [5:0] OpAndi    = 6'h0C;
    localparam logic [5:0] OpOri     = 6'h0D;
    localparam logic [5:0] OpXori    = 6'h0E;
    localparam logic [5:0] OpLui     = 6'h0F;
    localparam logic [5:0] FnJr      = 6'h08;
    localparam logic [5:0] FnJalr    = 6'h09;
    localparam logic [4:0] RtBltz    = 5'h00;
    localparam logic [4:0] RtBgez    = 5'h01;
    localparam logic [4:0] RtBltzal  = 5'h10;
    localparam logic [4:0] RtBgezal  = 5'h11;

    // Register count widened so NREG = 32 is representable
    localparam logic [5:0] NregW = 6'(NREG);

    // Instruction fields
    logic [5:0]  op;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] idx26;

    assign op    = instr_d[31:26];
    assign rs_a  = instr_d[25:21];
    assign rt_a  = instr_d[20:16];
    assign funct = instr_d[5:0];
    assign imm16 = instr_d[15:0];
    assign idx26 = instr_d[25:0];

    logic [DW-1:0] gpr [NREG];
    logic          write_ok;
    logic [DW-1:0] rf_rs;
    logic [DW-1:0] rf_rt;
    logic [DW-1:0] link_val;
    logic [DW-1:0] rs_v;
    logic [DW-1:0] rt_v;

    // $0 and out-of-range addresses are never written
    assign write_ok = we_w && (a3_w != 5'd0) && ({1'b0, a3_w} < NregW);

    // GPR file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                gpr[i] <= '0;
            end
        end else if (write_ok) begin
            gpr[a3_w] <= wd_w;
        end
    end

    // GPR read ports; $0 and out-of-range indices read as zero
    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if ((rs_a != 5'd0) && ({1'b0, rs_a} < NregW)) begin
            rf_rs = gpr[rs_a];
        end
        if ((rt_a != 5'd0) && ({1'b0, rt_a} < NregW)) begin
            rf_rt = gpr[rt_a];
        end
`ifdef DSTAGE_RF_BYPASS_EN
        if (write_ok && (rs_a == a3_w)) begin
            rf_rs = wd_w;
        end
        if (write_ok && (rt_a == a3_w)) begin
            rf_rt = wd_w;
        end
`endif
    end

    // Link value of the instruction in M wraps modulo 2^DW
    assign link_val = pc4_m + DW'(LINK_OFS);

    // Forwarding muxes selected by the hazard unit
    always_comb begin
        rs_v = rf_rs;
        rt_v = rf_rt;
        case (fwd_rs)
            2'd0: rs_v = rf_rs;
            2'd1: rs_v = alu_out_m;
            2'd2: rs_v = link_val;
            2'd3: rs_v = wd_w;
            default: rs_v = rf_rs;
        endcase
        case (fwd_rt)
            2'd0: rt_v = rf_rt;
            2'd1: rt_v = alu_out_m;
            2'd2: rt_v = link_val;
            2'd3: rt_v = wd_w;
            default: rt_v = rf_rt;
        endcase
    end

    logic          rs_zero;
    logic          rs_neg;
    logic          taken;
    logic          jump_abs;
    logic          jump_reg;
    logic          annul_link;
    logic [DW-1:0] sext;
    logic [DW-1:0] br_target;
    logic [DW-1:0] j_target;

    assign rs_zero   = (rs_v == '0);
    assign rs_neg    = rs_v[DW-1];
    assign sext      = {{(DW-16){imm16[15]}}, imm16};
    assign br_target = pc4_d + (sext << 2);
    assign j_target  = {pc4_d[DW-1:28], idx26, 2'b00};

    // Branch condition evaluation and jump classification
    always_comb begin
        taken      = 1'b0;
        jump_abs   = 1'b0;
        jump_reg   = 1'b0;
        annul_link = 1'b0;
        case (op)
            OpSpecial: jump_reg = (funct == FnJr) || (funct == FnJalr);
            OpJ, OpJal: jump_abs = 1'b1;
            OpBeq:  taken = (rs_v == rt_v);
            OpBne:  taken = (rs_v != rt_v);
            OpBlez: taken = rs_neg || rs_zero;
            OpBgtz: taken = !rs_neg && !rs_zero;
            OpRegimm: begin
                case (rt_a)
                    RtBltz:   taken = rs_neg;
                    RtBgez:   taken = !rs_neg;
                    RtBltzal: begin
                        taken      = rs_neg;
                        annul_link = !rs_neg;
                    end
                    RtBgezal: begin
                        taken      = !rs_neg;
                        annul_link = rs_neg;
                    end
                    default: taken = 1'b0;
                endcase
            end
            default: taken = 1'b0;
        endcase
    end

    // Redirect target; falls back to the branch target when nothing redirects
    always_comb begin
        npc = br_target;
        if (jump_reg) begin
            npc = rs_v;
        end else if (jump_abs) begin
            npc = j_target;
        end
    end

    assign pc_sel = (jump_abs || jump_reg || taken) && !stall_d && !reset;

    logic [DW-1:0] ext_v;

    // Immediate extension: logical ops zero-extend, lui shifts, everything else sign-extends
    always_comb begin
        ext_v = sext;
        case (op)
            OpAndi, OpOri, OpXori: ext_v = {{(DW-16){1'b0}}, imm16};
            OpLui:                 ext_v = {{(DW-16){1'b0}}, imm16} << 16;
            default:               ext_v = sext;
        endcase
    end

    // D/E pipeline register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            instr_e <= '0;
            rd1_e   <= '0;
            rd2_e   <= '0;
            ext_e   <= '0;
            pc4_e   <= '0;
            valid_e <= 1'b0;
        end else if (!stall_d) begin
            // A not-taken link branch must not write $31, so it moves on as a nop
            instr_e <= annul_link ? 32'd0 : instr_d;
            rd1_e   <= rs_v;
            rd2_e   <= rt_v;
            ext_e   <= ext_v;
            pc4_e   <= pc4_d;
            valid_e <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios plus randomized
// instructions checked against a spec-level reference model.
module tb_decode_stage_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] instr_d;
    logic [31:0] pc4_d;
    logic        we_w;
    logic [4:0]  a3_w;
    logic [31:0] wd_w;
    logic [31:0] alu_out_m;
    logic [31:0] pc4_m;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic        stall_d;
    logic        flush_e;
    logic [31:0] npc;
    logic        pc_sel;
    logic [31:0] instr_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] ext_e;
    logic [31:0] pc4_e;
    logic        valid_e;

    int checks = 0;
    int errors = 0;

    decode_stage_pipe #(.DW(32), .NREG(32), .LINK_OFS(4)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .pc4_d(pc4_d),
        .we_w(we_w), .a3_w(a3_w), .wd_w(wd_w), .alu_out_m(alu_out_m), .pc4_m(pc4_m),
        .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_d(stall_d), .flush_e(flush_e),
        .npc(npc), .pc_sel(pc_sel), .instr_e(instr_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .ext_e(ext_e), .pc4_e(pc4_e), .valid_e(valid_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] x_instr, x_rd1, x_rd2, x_ext, x_pc4;
    logic        x_valid;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DSTAGE_RF_BYPASS_EN
        if (we_w && a3_w == a) return wd_w;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_operand(input logic [1:0] sel, input logic [4:0] a);
        case (sel)
            2'd1: return alu_out_m;
            2'd2: return pc4_m + 32'd4;
            2'd3: return wd_w;
            default: return m_read(a);
        endcase
    endfunction

    // Spec-level decision for the instruction currently in D
    task automatic m_decide(output logic redir, output logic [31:0] tgt, output logic annul,
                            output logic [31:0] ext);
        logic [5:0]  op;
        logic [4:0]  rt;
        int signed   rsv;
        logic [31:0] rs_v, rt_v, simm;
        op    = instr_d[31:26];
        rt    = instr_d[20:16];
        rs_v  = m_operand(fwd_rs, instr_d[25:21]);
        rt_v  = m_operand(fwd_rt, instr_d[20:16]);
        rsv   = int'(rs_v);
        simm  = 32'(int'($signed(instr_d[15:0])));
        redir = 1'b0;
        annul = 1'b0;
        tgt   = pc4_d + simm * 4;
        if (op == 6'h02 || op == 6'h03) begin
            redir = 1'b1;
            tgt   = (pc4_d & 32'hF000_0000) | (instr_d[25:0] * 4);
        end else if (op == 6'h00 && (instr_d[5:0] == 6'h08 || instr_d[5:0] == 6'h09)) begin
            redir = 1'b1;
            tgt   = rs_v;
        end else if (op == 6'h04) redir = (rs_v == rt_v);
        else if (op == 6'h05) redir = (rs_v != rt_v);
        else if (op == 6'h06) redir = (rsv <= 0);
        else if (op == 6'h07) redir = (rsv > 0);
        else if (op == 6'h01) begin
            if (rt == 5'h00 || rt == 5'h10) redir = (rsv < 0);
            if (rt == 5'h01 || rt == 5'h11) redir = (rsv >= 0);
            if (rt == 5'h10 || rt == 5'h11) annul = !redir;
        end
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) ext = {16'd0, instr_d[15:0]};
        else if (op == 6'h0F) ext = {instr_d[15:0], 16'd0};
        else ext = simm;
    endtask

    // Advance one clock, updating the model with the inputs present at the edge
    task automatic tick();
        logic        redir, annul;
        logic [31:0] tgt, ext, rs_v, rt_v;
        m_decide(redir, tgt, annul, ext);
        rs_v = m_operand(fwd_rs, instr_d[25:21]);
        rt_v = m_operand(fwd_rt, instr_d[20:16]);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            {x_instr, x_rd1, x_rd2, x_ext, x_pc4, x_valid} = '0;
        end else begin
            if (we_w && a3_w != 5'd0) m_regs[a3_w] = wd_w;
            if (flush_e) begin
                {x_instr, x_rd1, x_rd2, x_ext, x_pc4, x_valid} = '0;
            end else if (!stall_d) begin
                x_instr = annul ? 32'd0 : instr_d;
                x_rd1   = rs_v;
                x_rd2   = rt_v;
                x_ext   = ext;
                x_pc4   = pc4_d;
                x_valid = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        instr_d = 32'd0; pc4_d = 32'd0; we_w = 1'b0; a3_w = 5'd0; wd_w = 32'd0;
        alu_out_m = 32'd0; pc4_m = 32'd0; fwd_rs = 2'd0; fwd_rt = 2'd0;
        stall_d = 1'b0; flush_e = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset   = 1'b1;
        instr_d = {6'h02, 26'h0000100};
        #1;
        checks++;
        if (pc_sel !== 1'b0) begin
            errors++; $display("FAIL reset_pc_sel got %0b want 0", pc_sel);
        end
        tick();
        tick();
        checks++;
        if ({instr_e, rd1_e, rd2_e, ext_e, pc4_e, valid_e} !== '0) begin
            errors++;
            $display("FAIL reset_e_fields got %h %h %h %h %h %b want all 0",
                     instr_e, rd1_e, rd2_e, ext_e, pc4_e, valid_e);
        end
        reset   = 1'b0;
        instr_d = {6'h08, 5'd5, 5'd6, 16'h0001};
        tick();
        checks++;
        if (rd1_e !== 32'd0) begin
            errors++; $display("FAIL reset_read_r5 got %h want 0", rd1_e);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        we_w = 1'b1; a3_w = 5'd8; wd_w = 32'h1234;
        tick();
        idle_inputs();
        instr_d   = {6'h04, 5'd8, 5'd9, 16'h0003};
        fwd_rt    = 2'd1;
        alu_out_m = 32'h1234;
        pc4_d     = 32'h3004;
        #1;
        checks++;
        if (pc_sel !== 1'b1) begin
            errors++; $display("FAIL beq_taken got %0b want 1", pc_sel);
        end
        checks++;
        if (npc !== 32'h3010) begin
            errors++; $display("FAIL beq_npc got %h want 00003010", npc);
        end
        tick();
    endtask

    task automatic test_bypass();
        logic [31:0] want;
`ifdef DSTAGE_RF_BYPASS_EN
        want = 32'hA5A5;
`else
        want = 32'h1234;
`endif
        idle_inputs();
        instr_d = {6'h08, 5'd8, 5'd0, 16'h0000};
        we_w = 1'b1; a3_w = 5'd8; wd_w = 32'hA5A5;
        tick();
        checks++;
        if (rd1_e !== want) begin
            errors++; $display("FAIL rf_write_through got %h want %h", rd1_e, want);
        end
    endtask

    task automatic test_link_annul();
        idle_inputs();
        instr_d   = {6'h01, 5'd4, 5'h11, 16'h0010};
        pc4_d     = 32'h4000;
        fwd_rs    = 2'd1;
        alu_out_m = 32'hFFFF_FFF0;
        #1;
        checks++;
        if (pc_sel !== 1'b0) begin
            errors++; $display("FAIL bgezal_neg_pc_sel got %0b want 0", pc_sel);
        end
        tick();
        checks++;
        if (instr_e !== 32'd0 || valid_e !== 1'b1) begin
            errors++; $display("FAIL bgezal_annul got instr %h valid %b want 0 1", instr_e, valid_e);
        end
        alu_out_m = 32'd0;
        #1;
        checks++;
        if (pc_sel !== 1'b1 || npc !== 32'h4040) begin
            errors++; $display("FAIL bgezal_taken got sel %b npc %h want 1 00004040", pc_sel, npc);
        end
        tick();
        checks++;
        if (instr_e !== 32'h0491_0010) begin
            errors++; $display("FAIL bgezal_kept got %h want 04910010", instr_e);
        end
    endtask

    task automatic test_jr_stall();
        idle_inputs();
        instr_d = {6'h00, 5'd31, 15'd0, 6'h08};
        fwd_rs  = 2'd2;
        pc4_m   = 32'h3008;
        #1;
        checks++;
        if (pc_sel !== 1'b1 || npc !== 32'h300C) begin
            errors++; $display("FAIL jr_link got sel %b npc %h want 1 0000300c", pc_sel, npc);
        end
        tick();
        stall_d = 1'b1;
        #1;
        checks++;
        if (pc_sel !== 1'b0) begin
            errors++; $display("FAIL jr_stall_pc_sel got %0b want 0", pc_sel);
        end
        instr_d = {6'h0F, 5'd0, 5'd2, 16'h7777};
        tick();
        checks++;
        if (instr_e !== 32'h03E0_0008 || rd1_e !== 32'h300C || valid_e !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got %h %h %b want 03e00008 0000300c 1",
                     instr_e, rd1_e, valid_e);
        end
    endtask

    task automatic test_flush_lui();
        idle_inputs();
        instr_d = {6'h0F, 5'd0, 5'd3, 16'h8001};
        stall_d = 1'b1;
        flush_e = 1'b1;
        tick();
        checks++;
        if (instr_e !== 32'd0 || valid_e !== 1'b0 || rd1_e !== 32'd0) begin
            errors++;
            $display("FAIL flush_over_stall got %h %b %h want 0 0 0", instr_e, valid_e, rd1_e);
        end
        stall_d = 1'b0;
        flush_e = 1'b0;
        tick();
        checks++;
        if (ext_e !== 32'h8001_0000 || valid_e !== 1'b1) begin
            errors++; $display("FAIL lui_ext got %h %b want 80010000 1", ext_e, valid_e);
        end
    endtask

    task automatic test_random();
        logic [5:0]  ops [16];
        logic [5:0]  op;
        logic [4:0]  rt;
        logic        redir, annul;
        logic [31:0] tgt, ext, vals [4];
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23, 6'h2B, 6'h3F};
        for (int n = 0; n < 400; n++) begin
            vals = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, $urandom};
            op = ops[$urandom_range(15)];
            rt = 5'($urandom);
            if (op == 6'h01) begin
                case ($urandom_range(4))
                    0: rt = 5'h00;
                    1: rt = 5'h01;
                    2: rt = 5'h10;
                    3: rt = 5'h11;
                    default: rt = 5'($urandom);
                endcase
            end
            instr_d = {op, 5'($urandom), rt, 16'($urandom)};
            if (op == 6'h00) instr_d[5:0] = ($urandom_range(1) == 0) ? 6'h08 : 6'h09;
            if (op == 6'h00 && $urandom_range(2) == 0) instr_d[5:0] = 6'h20;
            pc4_d     = {30'($urandom), 2'b00};
            we_w      = 1'($urandom);
            a3_w      = 5'($urandom);
            wd_w      = vals[$urandom_range(3)];
            alu_out_m = vals[$urandom_range(3)];
            pc4_m     = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : {30'($urandom), 2'b00};
            fwd_rs    = 2'($urandom);
            fwd_rt    = 2'($urandom);
            stall_d   = ($urandom_range(5) == 0);
            flush_e   = ($urandom_range(7) == 0);
            #1;
            m_decide(redir, tgt, annul, ext);
            checks++;
            if (pc_sel !== (redir && !stall_d)) begin
                errors++;
                $display("FAIL rand_pc_sel n=%0d instr %h got %b want %b",
                         n, instr_d, pc_sel, redir && !stall_d);
            end
            if (redir) begin
                checks++;
                if (npc !== tgt) begin
                    errors++;
                    $display("FAIL rand_npc n=%0d instr %h got %h want %h", n, instr_d, npc, tgt);
                end
            end
            tick();
            checks++;
            if ({instr_e, rd1_e, rd2_e, ext_e, pc4_e, valid_e} !==
                {x_instr, x_rd1, x_rd2, x_ext, x_pc4, x_valid}) begin
                errors++;
                $display("FAIL rand_e_fields n=%0d got %h %h %h %h %h %b want %h %h %h %h %h %b",
                         n, instr_e, rd1_e, rd2_e, ext_e, pc4_e, valid_e,
                         x_instr, x_rd1, x_rd2, x_ext, x_pc4, x_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_bypass();
        test_link_annul();
        test_jr_stall();
        test_flush_lui();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
